if_stage: RTL
=============

IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, the first fetch address after reset.
REQ-002 SHALL have parameter IMEM_BYTES, default 1600, the instruction memory size in bytes.
REQ-003 SHALL have port clk, input, 1, the single rising-edge clock.
REQ-004 SHALL have port rst_n, input, 1; reset is asynchronous and active-low.
REQ-005 SHALL have port stall, input, 1, meaning hold PC and the IF/ID register.
REQ-006 SHALL have port flush, input, 1, meaning load a bubble into IF/ID.
REQ-007 SHALL have port redirect, input, 1, meaning a branch/jump is taken.
REQ-008 SHALL have port redirect_pc, input, 32, the branch/jump target.
REQ-009 SHALL have port pc, output, 32, the current fetch address driven to the instruction memory PC input.
REQ-010 SHALL have port imem_inst, input, 32, the instruction word returned combinationally by the instruction memory for pc.
REQ-011 SHALL have ports id_valid (output, 1), id_pc (output, 32), id_pc4 (output, 32) and id_inst (output, 32); these form the IF/ID register.
REQ-012 SHALL have ports id_rd, id_rs1 and id_rs2, each output, 5; they carry id_inst[11:7], id_inst[19:15] and id_inst[24:20] respectively.
REQ-013 SHALL have port fetch_fault, output, 1, a sticky fetch-address fault flag.
REQ-014 SHALL have port fetch_count, output, 32, the number of accepted fetches.

Function
REQ-015 SHALL implement two states, RUN and HALT, and enter RUN on reset.
REQ-016 SHALL define a fetch as bad when pc[1:0] != 0 or pc > IMEM_BYTES-4.
REQ-017 SHALL apply the following priority in RUN at each rising edge: redirect, then bad fetch, then flush, then stall, then normal.
REQ-018 On redirect (RUN): pc <= redirect_pc; IF/ID <= bubble; fetch_count unchanged; redirect overrides both stall and flush.
REQ-019 On bad fetch (RUN, no redirect): next state HALT; fetch_fault <= 1; IF/ID <= bubble; pc holds.
REQ-020 On flush (RUN, no redirect, no bad fetch): IF/ID <= bubble; pc <= pc+4 if stall=0, else pc holds.
REQ-021 On stall alone (RUN): pc and IF/ID hold; fetch_count unchanged.
REQ-022 On normal (RUN): pc <= pc+4; IF/ID <= {id_valid=1, id_pc=pc, id_pc4=pc+4, id_inst=imem_inst}; fetch_count <= fetch_count+1.
REQ-023 A bubble SHALL be id_valid=0, id_inst=32'h0000_0013 (NOP), id_pc=0 and id_pc4=0.
REQ-024 id_rd, id_rs1 and id_rs2 SHALL be combinational slices of the registered id_inst; a bubble therefore gives all zero.
REQ-025 pc+4 SHALL wrap modulo 2^32.
REQ-026 fetch_count SHALL wrap from 32'hFFFF_FFFF to 0.
REQ-027 A redirect to a bad address SHALL be accepted; the fault is detected on the following edge.
REQ-028 In HALT, all inputs SHALL be ignored, pc and fetch_count SHALL hold, IF/ID SHALL hold a bubble, and fetch_fault SHALL stay 1.
REQ-029 HALT SHALL be exited only by reset.
REQ-030 The pc output SHALL be registered; there SHALL be no combinational path from any input to pc.
REQ-031 There SHALL be no combinational path from imem_inst to any output.

Reset
REQ-032 While rst_n=0, the block SHALL asynchronously force: state=RUN, pc=RESET_PC, IF/ID=bubble, fetch_fault=0, fetch_count=0.
REQ-033 Assertion of rst_n mid-operation, including in HALT, SHALL discard any in-flight fetch.
REQ-034 The first rising edge after rst_n deassertion SHALL perform a normal fetch of RESET_PC, unless stall, flush or redirect is active.

Verification
REQ-035 Reset release, imem_inst=32'h00500093 (addi x1,x0,5), 3 free-running cycles -> pc goes 0, 4, 8, 12; after edge 1, id_pc=0, id_inst=32'h00500093, id_rd=1, id_rs1=0, id_valid=1; fetch_count=3.
REQ-036 stall=1 for 2 cycles at pc=8 -> pc stays 8 and IF/ID unchanged; after release, next edge pc=12 and id_pc=8.
REQ-037 redirect=1, redirect_pc=32'h40, stall=1, flush=1 at pc=12 -> next pc=32'h40, id_valid=0, id_inst=32'h13; fetch_count unchanged.
REQ-038 redirect_pc=32'h42 -> edge 1 gives pc=32'h42; edge 2 gives fetch_fault=1, HALT, pc=32'h42; further redirects are ignored.
REQ-039 Sequential fetch reaching pc=1596 then 1600 (IMEM_BYTES=1600) -> 1596 is fetched as valid; at 1600, fetch_fault=1 and id_valid=0.
REQ-040 rst_n pulsed low asynchronously between edges while in HALT -> outputs immediately show pc=0, fetch_fault=0, fetch_count=0, id_valid=0.

Source files
------------

// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction fetch stage: PC register, IF/ID register, fetch fault halt
module if_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_BYTES = 1600
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        flush,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] pc,
  input  logic [31:0] imem_inst,
  output logic        id_valid,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc4,
  output logic [31:0] id_inst,
  output logic [4:0]  id_rd,
  output logic [4:0]  id_rs1,
  output logic [4:0]  id_rs2,
  output logic        fetch_fault,
  output logic [31:0] fetch_count
);

  localparam logic [31:0] NOP       = 32'h0000_0013;
  localparam logic [31:0] LAST_WORD = 32'(IMEM_BYTES - 4);

  typedef enum logic {RUN, HALT} state_t;

  state_t      state, state_nxt;
  logic [31:0] pc_nxt, id_pc_nxt, id_pc4_nxt, id_inst_nxt, count_nxt;
  logic        id_valid_nxt, fault_nxt;
  logic [31:0] pc_plus4;
  logic        bad_fetch;

  assign pc_plus4  = pc + 32'd4;
  assign bad_fetch = (pc[1:0] != 2'b00) || (pc > LAST_WORD);

  // Decoder register fields are plain slices of the registered instruction
  assign id_rd  = id_inst[11:7];
  assign id_rs1 = id_inst[19:15];
  assign id_rs2 = id_inst[24:20];

  // Next-state and next-register selection: redirect > bad fetch > flush > stall > fetch
  always_comb begin
    state_nxt    = state;
    pc_nxt       = pc;
    id_valid_nxt = id_valid;
    id_pc_nxt    = id_pc;
    id_pc4_nxt   = id_pc4;
    id_inst_nxt  = id_inst;
    count_nxt    = fetch_count;
    fault_nxt    = fetch_fault;
    if (state == HALT) begin
      id_valid_nxt = 1'b0;
      id_pc_nxt    = 32'd0;
      id_pc4_nxt   = 32'd0;
      id_inst_nxt  = NOP;
      fault_nxt    = 1'b1;
    end else if (redirect) begin
      pc_nxt       = redirect_pc;
      id_valid_nxt = 1'b0;
      id_pc_nxt    = 32'd0;
      id_pc4_nxt   = 32'd0;
      id_inst_nxt  = NOP;
    end else if (bad_fetch) begin
      state_nxt    = HALT;
      fault_nxt    = 1'b1;
      id_valid_nxt = 1'b0;
      id_pc_nxt    = 32'd0;
      id_pc4_nxt   = 32'd0;
      id_inst_nxt  = NOP;
    end else if (flush) begin
      id_valid_nxt = 1'b0;
      id_pc_nxt    = 32'd0;
      id_pc4_nxt   = 32'd0;
      id_inst_nxt  = NOP;
      if (!stall) pc_nxt = pc_plus4;
    end else if (!stall) begin
      pc_nxt       = pc_plus4;
      id_valid_nxt = 1'b1;
      id_pc_nxt    = pc;
      id_pc4_nxt   = pc_plus4;
      id_inst_nxt  = imem_inst;
      count_nxt    = fetch_count + 32'd1;
    end
  end

  // State, PC, IF/ID and status registers with asynchronous reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= RUN;
      pc          <= RESET_PC;
      id_valid    <= 1'b0;
      id_pc       <= 32'd0;
      id_pc4      <= 32'd0;
      id_inst     <= NOP;
      fetch_fault <= 1'b0;
      fetch_count <= 32'd0;
    end else begin
      state       <= state_nxt;
      pc          <= pc_nxt;
      id_valid    <= id_valid_nxt;
      id_pc       <= id_pc_nxt;
      id_pc4      <= id_pc4_nxt;
      id_inst     <= id_inst_nxt;
      fetch_fault <= fault_nxt;
      fetch_count <= count_nxt;
    end
  end

endmodule
